// File: rtl/sdram_resp_pkg.sv
// Shared types and constants for the SDRAM Avalon-MM burst responder.
package sdram_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR_BURST = 2'd1,
      ST_RD_ISSUE = 2'd2,
      ST_RD_DRAIN = 2'd3
   } state_t;

   // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, expressed as a bit mask of the tapped stages.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int DEFAULT_DATA_W = 128;
   localparam int BYTE_LANES     = DEFAULT_DATA_W / 8;

   function automatic int byte_lanes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sdram_avmm_if.sv
// Avalon-MM burst slave bus between the load/store engine initiator and the SDRAM responder.
interface sdram_avmm_if #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 128,
   parameter int BURST_W = 8
);
   // A command or write beat transfers on a rising edge where (avs_read | avs_write) is high and
   // avs_waitrequest is low; the master holds all command fields stable while waitrequest is high.
   // Read beats return later, one per cycle in which avs_readdatavalid is high, with no back-pressure.
   logic [ADDR_W-1:0]   avs_address;
   logic                avs_read;
   logic                avs_write;
   logic [DATA_W-1:0]   avs_writedata;
   logic [DATA_W/8-1:0] avs_byteenable;
   logic [BURST_W-1:0]  avs_burstcount;
   logic                avs_waitrequest;
   logic [DATA_W-1:0]   avs_readdata;
   logic                avs_readdatavalid;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
      input  avs_waitrequest, avs_readdata, avs_readdatavalid
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
      output avs_waitrequest, avs_readdata, avs_readdatavalid
   );
endinterface

// File: rtl/sdram_resp_ram.sv
// Single-clock word RAM: byte-enabled write port, registered read port (1-cycle latency), no reset.
module sdram_resp_ram
   import sdram_resp_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 128
) (
   input  logic                            clk,
   input  logic                            we,
   input  logic [ADDR_W-1:0]               waddr,
   input  logic [DATA_W-1:0]               wdata,
   input  logic [byte_lanes(DATA_W)-1:0]   be,
   input  logic                            re,
   input  logic [ADDR_W-1:0]               raddr,
   output logic [DATA_W-1:0]               rdata
);
   localparam int LANES = byte_lanes(DATA_W);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < LANES; b++) begin
            if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sdram_avmm_responder.sv
// Avalon-MM burst responder backed by an internal RAM; fixed, predictable cycle behaviour.
// Optional build macro SDRAM_RESP_BACKPRESSURE_EN adds LFSR-driven pseudo-random waitrequest stalls.
module sdram_avmm_responder
   import sdram_resp_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 128,
   parameter int BURST_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   sdram_avmm_if.slave  bus,
   output logic         resp_err,
   output state_t       dbg_state
);
   localparam logic [BURST_W-1:0] BC_ONE = BURST_W'(1);
   localparam logic [ADDR_W-1:0]  A_ONE  = ADDR_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BURST_W-1:0]  cnt_q, cnt_d;
   logic                err_d;
   logic                bp_stall;
   logic                wr_en, rd_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic                rd_valid_q;
   logic [DATA_W-1:0]   ram_q;
   logic                bc_zero;
   logic [BURST_W-1:0]  bc_eff;
   logic                acc_wr, acc_rd;

`ifdef SDRAM_RESP_BACKPRESSURE_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign bp_stall = (lfsr_q[1:0] == 2'b00);
`else
   assign bp_stall = 1'b0;
`endif

   // The stall term only matters in IDLE/WR_BURST; the read states already hold waitrequest high.
   assign bus.avs_waitrequest = rst | (state_q == ST_RD_ISSUE) | (state_q == ST_RD_DRAIN) | bp_stall;

   assign bc_zero = (bus.avs_burstcount == '0);
   assign bc_eff  = bc_zero ? BC_ONE : bus.avs_burstcount;
   assign acc_wr  = bus.avs_write & ~bus.avs_waitrequest;
   assign acc_rd  = bus.avs_read  & ~bus.avs_waitrequest;

   // In IDLE addr_q/cnt_q are don't-care; a write burst keeps the next beat address and beats left,
   // a read burst keeps the next address to issue and reads left.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = resp_err;
      wr_en   = 1'b0;
      wr_addr = addr_q;
      rd_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (acc_wr) begin
               wr_en   = 1'b1;
               wr_addr = bus.avs_address;
               addr_d  = bus.avs_address + A_ONE;
               cnt_d   = bc_eff - BC_ONE;
               if (bc_eff != BC_ONE) state_d = ST_WR_BURST;
               if (bc_zero || bus.avs_read) err_d = 1'b1;
            end else if (acc_rd) begin
               addr_d  = bus.avs_address;
               cnt_d   = bc_eff;
               state_d = ST_RD_ISSUE;
               if (bc_zero) err_d = 1'b1;
            end
         end
         ST_WR_BURST: begin
            if (bus.avs_read) err_d = 1'b1;
            if (acc_wr) begin
               wr_en  = 1'b1;
               addr_d = addr_q + A_ONE;
               cnt_d  = cnt_q - BC_ONE;
               if (cnt_q == BC_ONE) state_d = ST_IDLE;
            end
         end
         ST_RD_ISSUE: begin
            rd_en  = 1'b1;
            addr_d = addr_q + A_ONE;
            cnt_d  = cnt_q - BC_ONE;
            if (cnt_q == BC_ONE) state_d = ST_RD_DRAIN;
         end
         ST_RD_DRAIN: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         resp_err   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         resp_err   <= err_d;
         rd_valid_q <= rd_en;
      end
   end

   // RAM output is unreset, so gate it with the valid flag to present zero outside read beats.
   assign bus.avs_readdatavalid = rd_valid_q;
   assign bus.avs_readdata      = rd_valid_q ? ram_q : '0;
   assign dbg_state             = state_q;

   sdram_resp_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (bus.avs_writedata),
      .be    (bus.avs_byteenable),
      .re    (rd_en),
      .raddr (addr_q),
      .rdata (ram_q)
   );

endmodule
